// File: rtl/xor_output_stage.sv
// XOR network output neuron: multiply, sum/saturate, classify.
// Three-stage valid/ready pipeline; each stage holds one sample and
// accepts new data when it is empty or its contents move on this cycle.
module xor_output_stage #(
  parameter int unsigned             WIDTH  = 16,
  parameter int unsigned             FRAC   = 8,
  parameter logic signed [WIDTH-1:0] THRESH = WIDTH'(16'h0080)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] hidden1,
  input  logic signed [WIDTH-1:0] hidden2,
  input  logic signed [WIDTH-1:0] weight1,
  input  logic signed [WIDTH-1:0] weight2,
  input  logic signed [WIDTH-1:0] bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_value,
  output logic                    out_bit,
  output logic                    overflow
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned P_W    = 2 * WIDTH - FRAC;
  localparam int unsigned SUM_W  = P_W + 2;

  // Stage S1: scaled products and bias
  logic                    s1_valid;
  logic signed [P_W-1:0]   s1_p1;
  logic signed [P_W-1:0]   s1_p2;
  logic signed [WIDTH-1:0] s1_bias;

  // Stage S2: saturated sum
  logic                    s2_valid;
  logic signed [WIDTH-1:0] s2_value;
  logic                    s2_ovf;

  // Handshake: a stage loads when empty or when its contents advance
  logic s1_load_c, s1_adv_c;
  logic s2_load_c, s2_adv_c;
  logic s3_load_c, s3_adv_c;
  logic accept_c;

  assign s3_adv_c  = out_valid && out_ready;
  assign s3_load_c = !out_valid || s3_adv_c;
  assign s2_adv_c  = s2_valid && s3_load_c;
  assign s2_load_c = !s2_valid || s2_adv_c;
  assign s1_adv_c  = s1_valid && s2_load_c;
  assign s1_load_c = !s1_valid || s1_adv_c;
  assign in_ready  = s1_load_c;
  assign accept_c  = in_valid && s1_load_c;

  // Full-precision products; dropping the low FRAC bits is an arithmetic
  // shift right that rounds toward minus infinity
  logic signed [PROD_W-1:0] prod1_c;
  logic signed [PROD_W-1:0] prod2_c;
  logic                     unused_frac_c;

  assign prod1_c       = PROD_W'(hidden1) * PROD_W'(weight1);
  assign prod2_c       = PROD_W'(hidden2) * PROD_W'(weight2);
  assign unused_frac_c = ^{prod1_c[FRAC-1:0], prod2_c[FRAC-1:0]};

  // S1 register: products and bias captured on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p1    <= '0;
      s1_p2    <= '0;
      s1_bias  <= '0;
    end else begin
      if (s1_load_c) begin
        s1_valid <= in_valid;
      end
      if (accept_c) begin
        s1_p1   <= prod1_c[PROD_W-1:FRAC];
        s1_p2   <= prod2_c[PROD_W-1:FRAC];
        s1_bias <= bias;
      end
    end
  end

  // Sum wide enough that three operands cannot wrap
  logic signed [SUM_W-1:0] sum_c;
  logic signed [WIDTH-1:0] sat_c;
  logic                    sat_ovf_c;

  assign sum_c = SUM_W'(s1_p1) + SUM_W'(s1_p2) + SUM_W'(s1_bias);

  // Clamp to the WIDTH-bit signed range when the upper bits are not a pure sign extension
  always_comb begin
    sat_c     = sum_c[WIDTH-1:0];
    sat_ovf_c = 1'b0;
    if (!(&sum_c[SUM_W-1:WIDTH-1]) && (|sum_c[SUM_W-1:WIDTH-1])) begin
      sat_ovf_c = 1'b1;
      sat_c     = sum_c[SUM_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // S2 register: saturated sum and overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_value <= '0;
      s2_ovf   <= 1'b0;
    end else begin
      if (s2_load_c) begin
        s2_valid <= s1_valid;
      end
      if (s1_adv_c) begin
        s2_value <= sat_c;
        s2_ovf   <= sat_ovf_c;
      end
    end
  end

  // S3 register: result held stable until the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_value <= '0;
      out_bit   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (s3_load_c) begin
        out_valid <= s2_valid;
      end
      if (s2_adv_c) begin
        out_value <= s2_value;
        out_bit   <= (s2_value >= THRESH);
        overflow  <= s2_ovf;
      end
    end
  end

endmodule
